weight_bram_sequencer: RTL and testbench

- Sequences one neuron's weight BRAM (DEPTH words x 16 bit, negedge-clocked, EN/WE, read-first-not-write).
- Two modes:
  - LOAD: writes an incoming weight stream into addresses 0..DEPTH-1.
  - STREAM: reads addresses 0..DEPTH-1 in order and presents them to the MAC datapath through a valid/ready interface with full throughput and backpressure.
- Sits between the layer controller (start/mode/done) and one Weight_x_y BRAM instance.

---
 rtl/weight_bram_sequencer_if.sv | 35 +++
 rtl/weight_bram_sequencer.sv | 173 +++++++++++++++++
 tb/tb_weight_bram_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_bram_sequencer_if.sv
// Bundle of control, load-stream, output-stream and BRAM port signals for weight_bram_sequencer.
// master = sequencer side, slave = layer controller / MAC / BRAM side.
interface weight_bram_sequencer_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 16
);
    logic          start;
    logic          mode;
    logic [DW-1:0] load_data;
    logic          load_valid;
    logic          load_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_di;
    logic          bram_en;
    logic          bram_we;
    logic [DW-1:0] bram_do;

    modport master (
        input  start, mode, load_data, load_valid, out_ready, bram_do,
        output load_ready, out_data, out_valid, out_last, busy, done,
               bram_addr, bram_di, bram_en, bram_we
    );

    modport slave (
        output start, mode, load_data, load_valid, out_ready, bram_do,
        input  load_ready, out_data, out_valid, out_last, busy, done,
               bram_addr, bram_di, bram_en, bram_we
    );
endinterface

// File: rtl/weight_bram_sequencer.sv
// Loads or streams one neuron's weight BRAM (1-cycle read latency) behind valid/ready handshakes.
// Optional macro WSEQ_CHECKSUM_EN adds a running wrapping checksum output port.
module weight_bram_sequencer #(
    parameter int unsigned DEPTH = 28,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    weight_bram_sequencer_if.master bus
`ifdef WSEQ_CHECKSUM_EN
    ,
    output logic [DW-1:0]           checksum
`endif
);
    typedef enum logic [1:0] {StIdle, StLoad, StStream, StFinish} state_e;

    localparam logic [AW:0] DepthC   = (AW+1)'(DEPTH);
    localparam logic [AW:0] LastAddr = (AW+1)'(DEPTH - 1);

    state_e               state_q, state_d;
    logic [AW:0]          cnt_q, cnt_d;
    logic [1:0][DW-1:0]   fifo_data_q, fifo_data_d;
    logic [1:0]           fifo_last_q, fifo_last_d;
    logic [1:0]           fifo_cnt_q, fifo_cnt_d;
    logic                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                 inflight_q, inflight_d, inflight_last_q, inflight_last_d;
    logic                 bram_en_q, bram_en_d, bram_we_q, bram_we_d;
    logic [AW-1:0]        bram_addr_q, bram_addr_d;
    logic [DW-1:0]        bram_di_q, bram_di_d;
    logic                 load_fire, pop, push, issue;
    logic [1:0]           occ;
`ifdef WSEQ_CHECKSUM_EN
    logic [DW-1:0]        checksum_q, checksum_d;
`endif

    assign bus.load_ready = (state_q == StLoad);
    assign bus.busy       = (state_q == StLoad) || (state_q == StStream);
    assign bus.done       = (state_q == StFinish);
    assign bus.out_valid  = (fifo_cnt_q != 2'd0);
    assign bus.out_data   = fifo_data_q[rd_ptr_q];
    assign bus.out_last   = bus.out_valid && fifo_last_q[rd_ptr_q];
    assign bus.bram_en    = bram_en_q;
    assign bus.bram_we    = bram_we_q;
    assign bus.bram_addr  = bram_addr_q;
    assign bus.bram_di    = bram_di_q;

    assign load_fire = (state_q == StLoad) && bus.load_valid;
    assign pop       = bus.out_valid && bus.out_ready;
    assign push      = inflight_q;
    // A slot freed by this cycle's pop may be refilled by this cycle's read.
    assign occ       = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    assign issue     = (state_q == StStream) && (cnt_q < DepthC) && (occ < 2'd2);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        fifo_data_d     = fifo_data_q;
        fifo_last_d     = fifo_last_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        inflight_d      = 1'b0;
        inflight_last_d = inflight_last_q;
        bram_en_d       = 1'b0;
        bram_we_d       = 1'b0;
        bram_addr_d     = bram_addr_q;
        bram_di_d       = bram_di_q;
`ifdef WSEQ_CHECKSUM_EN
        checksum_d      = checksum_q;
`endif

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = bus.mode ? StLoad : StStream;
                    cnt_d   = '0;
`ifdef WSEQ_CHECKSUM_EN
                    checksum_d = '0;
`endif
                end
            end
            StLoad: begin
                if (load_fire) begin
                    bram_en_d   = 1'b1;
                    bram_we_d   = 1'b1;
                    bram_addr_d = cnt_q[AW-1:0];
                    bram_di_d   = bus.load_data;
                    cnt_d       = cnt_q + (AW+1)'(1);
`ifdef WSEQ_CHECKSUM_EN
                    checksum_d  = checksum_q + bus.load_data;
`endif
                    if (cnt_q == LastAddr) begin
                        state_d = StFinish;
                    end
                end
            end
            StStream: begin
                if (issue) begin
                    bram_en_d       = 1'b1;
                    bram_addr_d     = cnt_q[AW-1:0];
                    cnt_d           = cnt_q + (AW+1)'(1);
                    inflight_d      = 1'b1;
                    inflight_last_d = (cnt_q == LastAddr);
                end
                if (pop) begin
`ifdef WSEQ_CHECKSUM_EN
                    checksum_d = checksum_q + bus.out_data;
`endif
                    if (fifo_last_q[rd_ptr_q]) begin
                        state_d = StFinish;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if (push) begin
            fifo_data_d[wr_ptr_q] = bus.bram_do;
            fifo_last_d[wr_ptr_q] = inflight_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            fifo_data_q     <= '0;
            fifo_last_q     <= '0;
            fifo_cnt_q      <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            bram_en_q       <= 1'b0;
            bram_we_q       <= 1'b0;
            bram_addr_q     <= '0;
            bram_di_q       <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            fifo_data_q     <= fifo_data_d;
            fifo_last_q     <= fifo_last_d;
            fifo_cnt_q      <= fifo_cnt_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            bram_en_q       <= bram_en_d;
            bram_we_q       <= bram_we_d;
            bram_addr_q     <= bram_addr_d;
            bram_di_q       <= bram_di_d;
        end
    end

`ifdef WSEQ_CHECKSUM_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_weight_bram_sequencer.sv
// Scoreboard bench for weight_bram_sequencer: drivers push expected writes/words into queues,
// a negedge monitor pops and compares whenever the DUT writes the BRAM or hands out a word.
module tb_weight_bram_sequencer;
    localparam int unsigned DEPTH = 28;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    weight_bram_sequencer_if #(.AW(AW), .DW(DW)) ifc ();
`ifdef WSEQ_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    weight_bram_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(ifc)
`ifdef WSEQ_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    // Negedge-clocked read-first BRAM.
    logic [DW-1:0] mem [DEPTH];
    initial for (int a = 0; a < DEPTH; a++) mem[a] = '0;
    always @(negedge clk) begin
        if (ifc.bram_en) begin
            if (ifc.bram_we) mem[ifc.bram_addr] <= ifc.bram_di;
            ifc.bram_do <= mem[ifc.bram_addr];
        end
    end

    int npass = 0;
    int nchecks = 0;
    int cyc = 0;
    int start_cyc, last_pop_cyc, last_wr_cyc;
    int rd_issued, pops, done_seen, exp_done;
    bit op_load, first_valid_pending, prev_done;
    logic [DW-1:0] shadow [DEPTH];
    logic [AW+DW-1:0] exp_wr [$];
    logic [DW:0] exp_rd [$];
    logic [AW+DW-1:0] wr_item;
    logic [DW:0] rd_item;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input bit ok, input string name,
                                  input logic [31:0] act, input logic [31:0] req);
        nchecks++;
        if (ok) npass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.bram_en && !ifc.bram_we) begin
                rd_issued++;
                check(ifc.bram_addr < AW'(DEPTH), "rd_addr_range", 32'(ifc.bram_addr), DEPTH - 1);
                check(rd_issued - pops <= 2, "outstanding", rd_issued - pops, 2);
            end
            if (ifc.bram_en && ifc.bram_we) begin
                if (exp_wr.size() == 0) begin
                    check(1'b0, "unexpected_write", 32'(ifc.bram_addr), 0);
                end else begin
                    wr_item = exp_wr.pop_front();
                    check(ifc.bram_addr == wr_item[AW+DW-1:DW], "wr_addr",
                          32'(ifc.bram_addr), 32'(wr_item[AW+DW-1:DW]));
                    check(ifc.bram_di == wr_item[DW-1:0], "wr_data",
                          32'(ifc.bram_di), 32'(wr_item[DW-1:0]));
                end
                if (ifc.bram_addr == AW'(DEPTH - 1)) last_wr_cyc = cyc;
            end
            if (ifc.out_valid && first_valid_pending) begin
                first_valid_pending = 1'b0;
                check(cyc == start_cyc + 2, "first_valid_latency", cyc - start_cyc, 2);
            end
            if (ifc.out_valid && ifc.out_ready) begin
                pops++;
                if (exp_rd.size() == 0) begin
                    check(1'b0, "unexpected_word", 32'(ifc.out_data), 0);
                end else begin
                    rd_item = exp_rd.pop_front();
                    check(ifc.out_data == rd_item[DW-1:0], "out_data",
                          32'(ifc.out_data), 32'(rd_item[DW-1:0]));
                    check(ifc.out_last == rd_item[DW], "out_last",
                          32'(ifc.out_last), 32'(rd_item[DW]));
                end
                if (ifc.out_last) last_pop_cyc = cyc;
            end
            if (ifc.done) begin
                done_seen++;
                check(!prev_done, "done_pulse_width", 32'(prev_done), 0);
                check({ifc.busy, ifc.load_ready} == 2'b00, "done_idle_flags",
                      32'({ifc.busy, ifc.load_ready}), 0);
                check(cyc == (op_load ? last_wr_cyc : last_pop_cyc + 1), "done_timing",
                      cyc, op_load ? last_wr_cyc : last_pop_cyc + 1);
            end
            prev_done = ifc.done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic start_op(input logic m);
        @(posedge clk); #1;
        ifc.start = 1'b1;
        ifc.mode  = m;
        op_load = m;
        rd_issued = 0;
        pops = 0;
        first_valid_pending = !m;
        exp_done++;
        @(posedge clk); #1;
        start_cyc = cyc;
        ifc.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 300 && done_seen < exp_done; i++) begin
            @(posedge clk); #1;
        end
        check(done_seen == exp_done, name, done_seen, exp_done);
    endtask

    task automatic do_load(input logic [DW-1:0] base, input int step, input int gap);
        int  idx;
        bit  fire;
        idx = 0;
        start_op(1'b1);
        for (int t = 0; t < 1000 && idx < DEPTH; t++) begin
            ifc.load_valid = ((t % gap) == 0);
            ifc.load_data  = DW'(int'(base) + step * idx);
            ifc.start      = (gap > 1) && ((t % 5) == 2) && (idx < DEPTH - 2);
            ifc.mode       = 1'b0;
            @(negedge clk);
            fire = ifc.load_valid && ifc.load_ready;
            if (fire) begin
                exp_wr.push_back({AW'(idx), ifc.load_data});
                shadow[idx] = ifc.load_data;
                idx++;
            end
            @(posedge clk); #1;
        end
        ifc.load_valid = 1'b0;
        ifc.start      = 1'b0;
        wait_done("load_done");
        check(exp_wr.size() == 0, "load_writes_all", exp_wr.size(), 0);
        check(ifc.busy == 1'b0, "load_busy_after", 32'(ifc.busy), 0);
    endtask

    task automatic do_stream(input logic [3:0] pat, input string name);
        for (int a = 0; a < DEPTH; a++) exp_rd.push_back({(a == DEPTH - 1), shadow[a]});
        ifc.out_ready = pat[0];
        start_op(1'b0);
        for (int i = 0; i < 500 && done_seen < exp_done; i++) begin
            ifc.out_ready = pat[i % 4];
            @(posedge clk); #1;
        end
        ifc.out_ready = 1'b0;
        check(done_seen == exp_done, name, done_seen, exp_done);
        check(exp_rd.size() == 0, "stream_all_words", exp_rd.size(), 0);
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc.mode = 1'b0;
        ifc.load_data = '0;
        ifc.load_valid = 1'b0;
        ifc.out_ready = 1'b0;
        ifc.bram_do = '0;
        done_seen = 0;
        exp_done = 0;
        last_pop_cyc = 0;
        last_wr_cyc = 0;
        start_cyc = 0;
        rd_issued = 0;
        pops = 0;
        for (int a = 0; a < DEPTH; a++) shadow[a] = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check({ifc.load_ready, ifc.out_valid, ifc.out_last, ifc.busy, ifc.done, ifc.bram_en,
               ifc.bram_we, ifc.bram_addr, ifc.bram_di} == '0, "reset_outputs",
              32'({ifc.busy, ifc.done, ifc.bram_en, ifc.bram_we}), 0);

        // LOAD, continuous valid, data = addr + 0x100.
        do_load(16'h0100, 1, 1);

        // STREAM at full throughput: 28 words in 28 consecutive cycles.
        do_stream(4'b1111, "stream_full_done");
        check(last_pop_cyc == start_cyc + DEPTH + 1, "stream_throughput",
              last_pop_cyc - start_cyc, DEPTH + 1);

        // STREAM with out_ready pattern 1,0,0,1.
        do_stream(4'b1001, "stream_bp_done");

        // LOAD with valid every 3rd cycle and stray start pulses, then read back.
        do_load(16'h5A00, 3, 3);
        do_stream(4'b0110, "stream_gap_done");

        // Abort STREAM with RST after 10 words.
        for (int a = 0; a < DEPTH; a++) exp_rd.push_back({(a == DEPTH - 1), shadow[a]});
        ifc.out_ready = 1'b1;
        start_op(1'b0);
        for (int i = 0; i < 100 && pops < 10; i++) begin
            @(posedge clk); #1;
        end
        check(pops == 10, "abort_reach_word10", pops, 10);
        rst = 1'b1;
        ifc.out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rd.delete();
        exp_done--;
        @(negedge clk);
        check({ifc.load_ready, ifc.out_valid, ifc.out_last, ifc.busy, ifc.done, ifc.bram_en,
               ifc.bram_we, ifc.bram_addr, ifc.bram_di} == '0, "abort_outputs",
              32'({ifc.out_valid, ifc.busy, ifc.done, ifc.bram_en}), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check(!ifc.bram_en && !ifc.done, "abort_quiet", 32'({ifc.bram_en, ifc.done}), 0);
        end
        check(done_seen == exp_done, "abort_no_done", done_seen, exp_done);
        do_stream(4'b1111, "restream_done");

`ifdef WSEQ_CHECKSUM_EN
        do_load(16'hFFFF, 0, 1);
        check(checksum == 16'hFFE4, "checksum_load", 32'(checksum), 32'hFFE4);
        do_stream(4'b1111, "checksum_stream_done");
        check(checksum == 16'hFFE4, "checksum_stream", 32'(checksum), 32'hFFE4);
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end
endmodule
